// File: rtl/mux_scan_if.sv
// Handshake and mux-side signals between the scan sequencer and its consumer/bench.
interface mux_scan_if;
  logic       start;
  logic       cont;
  logic       stop;
  logic [7:0] ch_mask;
  logic       f_in;
  logic [2:0] sel;
  logic       g_n;
  logic       busy;
  logic [7:0] data_out;
  logic       data_valid;
  logic       changed;

  modport master (
    output start, cont, stop, ch_mask, f_in,
    input  sel, g_n, busy, data_out, data_valid, changed
  );

  modport slave (
    input  start, cont, stop, ch_mask, f_in,
    output sel, g_n, busy, data_out, data_valid, changed
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Sequencer for a 74LS151-style 8:1 mux: walks enabled channels, waits SETTLE
// cycles per channel, samples F and publishes an 8-bit snapshot per sweep.
module mux_scan_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  mux_scan_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SETUP, SAMPLE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [7:0] mask, shadow, snap, data_r;
  logic [2:0] sel_r, low_ch, next_ch;
  logic       low_vld, next_vld, dv_r, chg_r;

  // Lowest channel of the live input mask, used whenever a sweep (re)starts.
  always_comb begin
    low_vld = 1'b0;
    low_ch  = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (bus.ch_mask[i]) begin
        low_vld = 1'b1;
        low_ch  = 3'(i);
      end
  end

  always_comb begin
    next_vld = 1'b0;
    next_ch  = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (mask[i] && i > int'(sel_r)) begin
        next_vld = 1'b1;
        next_ch  = 3'(i);
      end
  end

  always_comb begin
    snap        = shadow;
    snap[sel_r] = bus.f_in;
    snap        = snap & mask;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // stop outranks both a new start and sweep completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && !bus.stop && low_vld) state_nxt = SETUP;
      SETUP:   if (bus.stop) state_nxt = IDLE;
               else if (cnt == CNT_LAST) state_nxt = SAMPLE;
      SAMPLE:  if (bus.stop) state_nxt = IDLE;
               else if (next_vld || (bus.cont && low_vld)) state_nxt = SETUP;
               else state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      mask   <= '0;
      shadow <= '0;
      sel_r  <= '0;
      data_r <= '0;
      dv_r   <= 1'b0;
      chg_r  <= 1'b0;
    end else begin
      dv_r  <= 1'b0;
      chg_r <= 1'b0;
      case (state)
        IDLE: if (state_nxt == SETUP) begin
          mask   <= bus.ch_mask;
          sel_r  <= low_ch;
          cnt    <= '0;
          shadow <= '0;
        end
        SETUP: cnt <= cnt + 4'd1;
        SAMPLE: if (!bus.stop) begin
          shadow[sel_r] <= bus.f_in;
          if (next_vld) begin
            sel_r <= next_ch;
            cnt   <= '0;
          end else begin
            data_r <= snap;
            dv_r   <= 1'b1;
            chg_r  <= (snap != data_r);
            if (state_nxt == SETUP) begin
              mask   <= bus.ch_mask;
              sel_r  <= low_ch;
              cnt    <= '0;
              shadow <= '0;
            end
          end
        end
        default: ;
      endcase
      if (state_nxt == IDLE) sel_r <= '0;
    end
  end

  always_comb begin
    bus.g_n        = (state == IDLE);
    bus.busy       = (state != IDLE);
    bus.sel        = sel_r;
    bus.data_out   = data_r;
    bus.data_valid = dv_r;
    bus.changed    = chg_r;
  end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: models the mux (F = g_n ? 0 : D[sel]) and scoreboards snapshots.
module tb_mux_scan_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] d;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0;
  logic [8:0] exp_q[$];
  int vld_log[$];
  logic [2:0] sel_log[$];

  mux_scan_if bus();

  mux_scan_ctrl #(.SETTLE(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb bus.f_in = bus.g_n ? 1'b0 : d[bus.sel];

  // Scoreboard: each data_valid pops one {data_out, changed} expectation.
  always @(negedge clk) begin
    if (!rst && bus.busy) sel_log.push_back(bus.sel);
    if (!rst && bus.data_valid) begin
      logic [8:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL snapshot: unexpected data_valid, data_out=%h", bus.data_out);
      end else begin
        e = exp_q.pop_front();
        if ({bus.data_out, bus.changed} !== e) begin
          errors++;
          $display("FAIL snapshot: got data=%h changed=%b, need data=%h changed=%b",
                   bus.data_out, bus.changed, e[8:1], e[0]);
        end
      end
      vld_log.push_back(cyc);
    end
  end

  task automatic wait_vld(input int n, input int budget);
    int k = 0;
    while (vld_log.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (vld_log.size() < n) begin
      errors++;
      $display("FAIL wait_vld: got %0d pulses, need %0d", vld_log.size(), n);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    bus.start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_sel_trace(input logic [7:0] m);
    logic [2:0] e[$];
    for (int i = 0; i < 8; i++)
      if (m[i]) repeat (3) e.push_back(3'(i));
    checks++;
    if (sel_log.size() != e.size()) begin
      errors++;
      $display("FAIL sel_trace_len: got %0d, need %0d", sel_log.size(), e.size());
    end else
      for (int i = 0; i < e.size(); i++) begin
        checks++;
        if (sel_log[i] !== e[i]) begin
          errors++;
          $display("FAIL sel_trace[%0d]: got %0d, need %0d", i, sel_log[i], e[i]);
        end
      end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] exp_data);
    @(negedge clk);
    checks++;
    if ({bus.sel, bus.g_n, bus.busy, bus.data_out, bus.data_valid, bus.changed} !==
        {3'd0, 1'b1, 1'b0, exp_data, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s: got sel=%0d g_n=%b busy=%b data=%h dv=%b chg=%b, need idle data=%h",
               tag, bus.sel, bus.g_n, bus.busy, bus.data_out, bus.data_valid, bus.changed, exp_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_cycles(3);
    check_idle_outputs("reset", 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full_sweep();
    d = 8'hA5; bus.ch_mask = 8'hFF; bus.cont = 1'b0;
    exp_q.push_back({8'hA5, 1'b1});
    sel_log.delete(); vld_log.delete();
    pulse_start();
    wait_vld(1, 40);
    checks++;
    if (vld_log[0] - t0 !== 24) begin
      errors++;
      $display("FAIL full_latency: got %0d, need 24", vld_log[0] - t0);
    end
    check_sel_trace(8'hFF);
    check_idle_outputs("full_after", 8'hA5);
  endtask

  task automatic test_sparse_mask();
    d = 8'hFF; bus.ch_mask = 8'h81;
    exp_q.push_back({8'h81, 1'b1});
    sel_log.delete(); vld_log.delete();
    pulse_start();
    wait_vld(1, 20);
    checks++;
    if (vld_log[0] - t0 !== 6) begin
      errors++;
      $display("FAIL sparse_latency: got %0d, need 6", vld_log[0] - t0);
    end
    check_sel_trace(8'h81);
    check_idle_outputs("sparse_after", 8'h81);
  endtask

  task automatic test_continuous();
    d = 8'h3C; bus.ch_mask = 8'hFF; bus.cont = 1'b1;
    exp_q.push_back({8'h3C, 1'b1});
    exp_q.push_back({8'h3D, 1'b1});
    exp_q.push_back({8'h3D, 1'b0});
    vld_log.delete();
    pulse_start();
    wait_vld(1, 40);
    d = 8'h3D;
    wait_vld(2, 40);
    bus.cont = 1'b0;
    wait_vld(3, 40);
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (vld_log[i] - vld_log[i-1] !== 24) begin
        errors++;
        $display("FAIL cont_spacing[%0d]: got %0d, need 24", i, vld_log[i] - vld_log[i-1]);
      end
    end
    check_idle_outputs("cont_after", 8'h3D);
  endtask

  task automatic test_stop();
    d = 8'h55; bus.ch_mask = 8'hFF;
    vld_log.delete();
    pulse_start();
    idle_cycles(10);
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
    check_idle_outputs("stop_idle", 8'h3D);
    idle_cycles(30);
    checks++;
    if (vld_log.size() !== 0) begin
      errors++;
      $display("FAIL stop_no_valid: got %0d pulses, need 0", vld_log.size());
    end
    // stop wins over a simultaneous start
    bus.start = 1'b1; bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
    check_idle_outputs("stop_start", 8'h3D);
    // restart; a mid-sweep mask change must be ignored
    exp_q.push_back({8'h55, 1'b1});
    pulse_start();
    idle_cycles(4);
    bus.ch_mask = 8'h01;
    bus.start = 1'b1;
    idle_cycles(2);
    bus.start = 1'b0;
    wait_vld(1, 40);
    checks++;
    if (vld_log[0] - t0 !== 24) begin
      errors++;
      $display("FAIL restart_latency: got %0d, need 24", vld_log[0] - t0);
    end
    check_idle_outputs("restart_after", 8'h55);
  endtask

  task automatic test_reset_mid();
    int busy_seen = 0;
    d = 8'hF0; bus.ch_mask = 8'hFF;
    vld_log.delete();
    pulse_start();
    idle_cycles(8);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("reset_mid", 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;
    bus.ch_mask = 8'h00;
    pulse_start();
    repeat (6) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) busy_seen++;
    end
    checks++;
    if (busy_seen != 0 || vld_log.size() != 0) begin
      errors++;
      $display("FAIL zero_mask: got busy cycles=%0d pulses=%0d, need 0 and 0",
               busy_seen, vld_log.size());
    end
  endtask

  initial begin
    rst = 1'b1; d = 8'h00;
    bus.start = 1'b0; bus.cont = 1'b0; bus.stop = 1'b0; bus.ch_mask = 8'h00;
    test_reset();
    test_full_sweep();
    test_sparse_mask();
    test_continuous();
    test_stop();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, need 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
